// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads a program from word-addressed instruction
// memory into a 2-entry in-order buffer and hands instructions to the core.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for enable; fetch address is reloaded with 0 on exit
// RUN   | issuing reads while fetch address < endAddr
// DRAIN | all reads issued; waiting for buffer empty, no read pending, core idle
// DONE  | program complete; done=1 until enable drops
module instruction_fetch #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDR_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        endAddr,
  output logic                         memReq,
  output logic [ADDR_WIDTH-1:0]        memAddr,
  input  logic                         memValid,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic                         start,
  input  logic                         busy,
  input  logic                         redirectValid,
  input  logic [ADDR_WIDTH-1:0]        redirectAddr,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                         state;
  logic [ADDR_WIDTH-1:0]          fetch_pc;
  logic [ADDR_WIDTH-1:0]          req_addr;
  logic [1:0]                     count;
  logic                           head;
  logic                           outstanding;
  logic                           discard;
  logic [INSTRUCTION_WIDTH-1:0]   buf_data [2];
  logic [ADDR_WIDTH-1:0]          buf_addr [2];

  logic                           non_empty;
  logic                           issue;
  logic                           resp;
  logic                           push;
  logic                           pop;
  logic                           tail;
  logic                           redirect_in_range;
  logic [ADDR_WIDTH-1:0]          redirect_pc;

  // Issue/accept decisions and the handshake outputs; every output is
  // forced to 0 while reset is held, independent of the registered state.
  // A redirect also blocks issue so no read is launched for the stale path.
  always_comb begin
    non_empty         = (count != 2'd0);
    issue             = reset && (state == RUN) && enable && !redirectValid &&
                        (fetch_pc < endAddr) && !outstanding && (count != 2'd2);
    resp              = memValid && outstanding;
    push              = resp && !discard && !redirectValid;
    pop               = reset && non_empty && !busy && !redirectValid;
    tail              = (count == 2'd1) ? ~head : head;
    redirect_in_range = (redirectAddr < endAddr);
    redirect_pc       = redirect_in_range ? redirectAddr : endAddr;

    memReq         = issue;
    memAddr        = reset ? fetch_pc : '0;
    start          = pop;
    instructionOut = (reset && non_empty) ? buf_data[head] : '0;
    pc             = (reset && non_empty) ? buf_addr[head] : '0;
    done           = reset && (state == DONE);
  end

  // Buffer payload: accepted read data goes to the tail with its address.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= memData;
      buf_addr[tail] <= req_addr;
    end
  end

  // Control: FSM, fetch address, buffer pointers and the single read slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= '0;
      req_addr    <= '0;
      count       <= 2'd0;
      head        <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirectValid) begin
        // A response landing with the redirect is consumed and dropped;
        // otherwise the pending one is tagged to be dropped on arrival.
        count       <= 2'd0;
        head        <= 1'b0;
        outstanding <= outstanding && !memValid;
        discard     <= outstanding && !memValid;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) head <= ~head;
        if (resp) begin
          outstanding <= 1'b0;
          discard     <= 1'b0;
        end
        if (issue) begin
          outstanding <= 1'b1;
          req_addr    <= fetch_pc;
          fetch_pc    <= fetch_pc + ADDR_ONE;
        end
      end

      if (state == IDLE) begin
        if (enable) begin
          fetch_pc <= '0;
          state    <= (endAddr == '0) ? DRAIN : RUN;
        end
      end else if (redirectValid) begin
        fetch_pc <= redirect_pc;
        state    <= redirect_in_range ? RUN : DRAIN;
      end else begin
        case (state)
          RUN:     if (issue && ((fetch_pc + ADDR_ONE) == endAddr)) state <= DRAIN;
          DRAIN:   if (!non_empty && !outstanding && !busy) state <= DONE;
          DONE:    if (!enable) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a queue-based reference of the fetch unit,
// a latency-programmable in-order memory, directed scenarios and random runs.
module tb_instruction_fetch;
  localparam int IW = 32;
  localparam int AW = 16;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, memValid, busy, redirectValid;
  logic [AW-1:0] endAddr, redirectAddr, memAddr, pc;
  logic [IW-1:0] memData, instructionOut;
  logic          memReq, start, done;

  instruction_fetch #(.INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .endAddr(endAddr),
    .memReq(memReq), .memAddr(memAddr), .memValid(memValid), .memData(memData),
    .instructionOut(instructionOut), .start(start), .busy(busy),
    .redirectValid(redirectValid), .redirectAddr(redirectAddr),
    .pc(pc), .done(done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {int a; logic [IW-1:0] d;} ent_t;
  typedef struct {int a; int due;} mreq_t;

  // reference state
  ent_t mq[$];
  int   ph, fpc, oaddr;
  bit   opend, odrop;

  // memory model
  mreq_t memq[$];
  int    last_due = 0;
  int    lat_lo = 1, lat_hi = 1;
  bit    spur_en = 1'b0;

  // observation log
  int got_pc[$];
  int first_req, first_start, first_req_addr, last_req_addr, req_count, max_occ;

  function automatic logic [IW-1:0] memfun(int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs against the reference, then advance the reference
  // to the state after the coming posedge.
  task automatic check_and_advance();
    int n, ea, ra;
    bit e_req, e_start, e_done, resp, was_pend;
    logic [IW-1:0] e_instr;
    int e_pc;
    n  = mq.size();
    ea = int'(endAddr);
    ra = int'(redirectAddr);
    e_start = reset && (n > 0) && !busy && !redirectValid;
    e_instr = (reset && n > 0) ? mq[0].d : '0;
    e_pc    = (reset && n > 0) ? mq[0].a : 0;
    e_req   = reset && (ph == P_RUN) && enable && !redirectValid && (fpc < ea) && !opend && (n < 2);
    e_done  = reset && (ph == P_DONE);

    chk("memReq", 64'(memReq), 64'(e_req));
    chk("start", 64'(start), 64'(e_start));
    chk("instructionOut", 64'(instructionOut), 64'(e_instr));
    chk("pc", 64'(pc), 64'(e_pc));
    chk("done", 64'(done), 64'(e_done));
    if (e_req || !reset) chk("memAddr", 64'(memAddr), e_req ? 64'(fpc) : 64'd0);

    if (reset && memReq === 1'b1) begin
      int d;
      d = cyc + $urandom_range(lat_lo, lat_hi);
      if (d <= last_due) d = last_due + 1;
      memq.push_back('{int'(memAddr), d});
      last_due = d;
      last_req_addr = int'(memAddr);
    end

    if (e_start) begin
      got_pc.push_back(e_pc);
      chk("handed data", 64'(e_instr), 64'(memfun(e_pc)));
      if (first_start < 0) first_start = cyc;
    end
    if (e_req) begin
      req_count++;
      if (first_req < 0) begin
        first_req = cyc;
        first_req_addr = fpc;
      end
    end

    if (!reset) begin
      ph = P_IDLE; fpc = 0; mq.delete(); opend = 0; odrop = 0;
    end else begin
      resp     = memValid && opend;
      was_pend = opend;
      if (ph == P_IDLE) begin
        if (enable) begin
          fpc = 0;
          ph  = (ea == 0) ? P_DRAIN : P_RUN;
        end
      end else if (redirectValid) begin
        fpc = (ra < ea) ? ra : ea;
        ph  = (ra < ea) ? P_RUN : P_DRAIN;
      end else if (ph == P_RUN) begin
        if (e_req && fpc + 1 == ea) ph = P_DRAIN;
      end else if (ph == P_DRAIN) begin
        if (n == 0 && !was_pend && !busy) ph = P_DONE;
      end else if (!enable) begin
        ph = P_IDLE;
      end

      if (redirectValid) begin
        mq.delete();
        odrop = opend && !memValid;
        opend = opend && !memValid;
      end else begin
        if (e_start) void'(mq.pop_front());
        if (resp) begin
          if (!odrop) mq.push_back('{oaddr, memData});
          opend = 0;
          odrop = 0;
        end
        if (e_req) begin
          opend = 1;
          oaddr = fpc;
          fpc++;
        end
      end
    end
    if (mq.size() > max_occ) max_occ = mq.size();
  endtask

  task automatic drive_memory();
    memValid = 1'b0;
    memData  = $urandom;
    if (memq.size() > 0) begin
      if (memq[0].due <= cyc) begin
        memValid = 1'b1;
        memData  = memfun(memq[0].a);
        void'(memq.pop_front());
      end
    end else if (spur_en && $urandom_range(0, 19) == 0) begin
      memValid = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
    cyc++;
    drive_memory();
  endtask

  task automatic clear_log();
    got_pc.delete();
    first_req = -1; first_start = -1; first_req_addr = -1; last_req_addr = -1;
    req_count = 0; max_occ = 0;
  endtask

  task automatic run_until_done(string name, int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    chk({name, " done reached"}, 64'(done), 64'd1);
  endtask

  task automatic chk_run(string name, int idx0, int first, int n);
    for (int i = 0; i < n; i++) begin
      if (idx0 + i < got_pc.size()) chk(name, 64'(got_pc[idx0 + i]), 64'(first + i));
      else chk({name, " missing"}, 64'hFFFF, 64'(first + i));
    end
  endtask

  task automatic finish_program();
    enable = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; enable = 1'b0; busy = 1'b0; redirectValid = 1'b0;
    redirectAddr = '0; endAddr = '0; memValid = 1'b0; memData = '0;
    ph = P_IDLE; fpc = 0; opend = 0; odrop = 0; oaddr = 0;
    clear_log();

    tick(); tick();
    chk("reset memReq", 64'(memReq), 64'd0);
    chk("reset start", 64'(start), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset pc", 64'(pc), 64'd0);
    reset = 1'b1;
    tick();

    // three-instruction program, single-cycle memory
    endAddr = 16'd3; lat_lo = 1; lat_hi = 1; clear_log();
    enable = 1'b1;
    run_until_done("t1", 50);
    chk("t1 count", 64'(got_pc.size()), 64'd3);
    chk_run("t1 order", 0, 0, 3);
    chk("t1 req-to-start latency", 64'(first_start - first_req), 64'd2);
    finish_program();

    // core stalls for 5 cycles after the first hand-over
    endAddr = 16'd4; clear_log();
    enable = 1'b1;
    n = 0;
    while (got_pc.size() == 0 && n < 50) begin tick(); n++; end
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    run_until_done("t2", 50);
    chk("t2 buffer fill", 64'(max_occ), 64'd2);
    chk("t2 count", 64'(got_pc.size()), 64'd4);
    chk_run("t2 order", 0, 0, 4);
    finish_program();

    // redirect while the read for address 2 is in flight
    endAddr = 16'd12; lat_lo = 3; lat_hi = 3; clear_log();
    enable = 1'b1;
    n = 0;
    while (last_req_addr != 2 && n < 60) begin tick(); n++; end
    redirectValid = 1'b1; redirectAddr = 16'd10;
    first_req = -1;
    tick();
    redirectValid = 1'b0;
    run_until_done("t3", 80);
    chk("t3 count", 64'(got_pc.size()), 64'd4);
    chk_run("t3 before", 0, 0, 2);
    chk_run("t3 after", 2, 10, 2);
    chk("t3 first addr after redirect", 64'(first_req_addr), 64'd10);
    finish_program();

    // empty program
    endAddr = 16'd0; clear_log();
    enable = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 10) begin tick(); n++; end
    chk("t4 cycles to done", 64'(n), 64'd2);
    chk("t4 requests", 64'(req_count), 64'd0);
    finish_program();

    // reset pulse with a read in flight
    endAddr = 16'd4; lat_lo = 3; lat_hi = 3; clear_log();
    enable = 1'b1;
    n = 0;
    while (last_req_addr != 1 && n < 60) begin tick(); n++; end
    reset = 1'b0;
    #1;
    chk("t5 memReq in reset", 64'(memReq), 64'd0);
    chk("t5 start in reset", 64'(start), 64'd0);
    chk("t5 instr in reset", 64'(instructionOut), 64'd0);
    chk("t5 pc in reset", 64'(pc), 64'd0);
    chk("t5 memAddr in reset", 64'(memAddr), 64'd0);
    tick();
    reset = 1'b1;
    clear_log();
    run_until_done("t5", 80);
    chk("t5 restart addr", 64'(first_req_addr), 64'd0);
    chk("t5 count", 64'(got_pc.size()), 64'd4);
    chk_run("t5 order", 0, 0, 4);
    finish_program();

    // slow memory
    endAddr = 16'd5; lat_lo = 3; lat_hi = 3; clear_log();
    enable = 1'b1;
    run_until_done("t6", 80);
    chk("t6 start pulses", 64'(got_pc.size()), 64'd5);
    chk_run("t6 order", 0, 0, 5);
    finish_program();

    // randomized programs
    for (int ep = 0; ep < 40; ep++) begin
      reset = 1'b0; enable = 1'b0; busy = 1'b0; redirectValid = 1'b0; spur_en = 1'b0;
      for (int k = 0; k < 20 && (k < 2 || memq.size() > 0); k++) tick();
      endAddr = AW'($urandom_range(0, 7));
      lat_lo  = $urandom_range(1, 2);
      lat_hi  = lat_lo + $urandom_range(0, 2);
      clear_log();
      reset = 1'b1; enable = 1'b1; spur_en = 1'b1;
      repeat (60) begin
        busy          = ($urandom_range(0, 2) == 0);
        redirectValid = ($urandom_range(0, 14) == 0);
        redirectAddr  = AW'($urandom_range(0, int'(endAddr) + 2));
        enable        = ($urandom_range(0, 9) != 0);
        tick();
      end
      busy = 1'b0; redirectValid = 1'b0; enable = 1'b1;
      run_until_done("random", 300);
      enable = 1'b0;
      tick();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
- REQ-001: Parameter INSTRUCTION_WIDTH, default 32, width of one instruction word.
- REQ-002: Parameter ADDR_WIDTH, default 16, width of the word-indexed program address.
- REQ-003: clk  input  1  sole clock; all state updates on posedge clk.
- REQ-004: reset  input  1  synchronous, active-low reset; sampled on posedge clk, asserted when 0.
- REQ-005: enable  input  1  run request; fetching starts or continues only while 1.
- REQ-006: endAddr  input  ADDR_WIDTH  program length in words; valid addresses are 0..endAddr-1; stable while enable=1.
- REQ-007: memReq  output  1  instruction memory read request, one cycle per request.
- REQ-008: memAddr  output  ADDR_WIDTH  word address for memReq.
- REQ-009: memValid  input  1  read data valid; at least 1 cycle after the matching memReq, responses in order.
- REQ-010: memData  input  INSTRUCTION_WIDTH  read data, qualified by memValid.
- REQ-011: instructionOut  output  INSTRUCTION_WIDTH  instruction presented to core.instructionIn.
- REQ-012: start  output  1  instructionOut is valid; core accepts it on any cycle with start=1.
- REQ-013: busy  input  1  core busy; no instruction is handed over while 1.
- REQ-014: redirectValid  input  1  one-cycle request to restart fetch at redirectAddr.
- REQ-015: redirectAddr  input  ADDR_WIDTH  new fetch address.
- REQ-016: pc  output  ADDR_WIDTH  address of the instruction currently on instructionOut.
- REQ-017: done  output  1  program complete: all instructions handed over and core idle.

Function
- REQ-018: FSM states IDLE, RUN, DRAIN, DONE.
- REQ-019: IDLE -> RUN when enable=1; fetchPc loaded with 0 on the transition.
- REQ-020: RUN -> DRAIN when fetchPc = endAddr after an issue; endAddr=0 goes IDLE -> DRAIN directly.
- REQ-021: DRAIN -> DONE when the buffer is empty, no request is outstanding and busy=0.
- REQ-022: DONE -> IDLE when enable=0; done=1 only in DONE.
- REQ-023: enable=0 in RUN or DRAIN stops new memReq issue; in-flight data is still buffered and handed over.
- REQ-024: 2-entry in-order instruction buffer, each entry storing instruction and its address.
- REQ-025: memReq=1 only in RUN, with enable=1, fetchPc<endAddr, no request outstanding, and buffer occupancy < 2; memAddr=fetchPc; fetchPc increments by 1 on each issue.
- REQ-026: At most one outstanding request; memValid with no outstanding request is ignored.
- REQ-027: memValid writes memData into the buffer tail the same cycle; a memValid arriving with a simultaneous pop is accepted.
- REQ-028: start = buffer non-empty AND busy=0 AND redirectValid=0 (combinational).
- REQ-029: instructionOut and pc show the buffer head whenever the buffer is non-empty; they are 0 when it is empty.
- REQ-030: A cycle with start=1 pops the head at the posedge.
- REQ-031: Minimum latency: memReq in cycle N, memValid in N+1 -> start in N+2 when busy=0.
- REQ-032: redirectValid=1 flushes the buffer, sets fetchPc=redirectAddr and marks any outstanding response for discard, so its memValid is dropped.
- REQ-033: A redirect in DRAIN or DONE returns the FSM to RUN when redirectAddr<endAddr, otherwise to DRAIN.
- REQ-034: redirectValid has priority over pop and memValid in the same cycle.
- REQ-035: fetchPc never exceeds endAddr and never wraps.

Reset
- REQ-036: reset=0 at posedge forces: state IDLE, fetchPc=0, buffer empty, outstanding and discard flags cleared.
- REQ-037: Outputs while reset is asserted: memReq=0, memAddr=0, start=0, instructionOut=0, pc=0, done=0.
- REQ-038: Reset mid-operation has the same effect as REQ-036/037, and a memValid arriving later for a pre-reset request is ignored.

Verification
- REQ-039: endAddr=3, memory {A,B,C}, 1-cycle memory, busy=0 -> A,B,C on consecutive start cycles with pc 0,1,2; done=1 afterwards.
- REQ-040: endAddr=4, busy held 1 for 5 cycles after first start -> buffer fills to 2, memReq stalls, no instruction lost or duplicated, order 0..3.
- REQ-041: Redirect to 10 while a request for 2 is outstanding (endAddr=12) -> data for 2 dropped; next handed instructions are pc 10, 11; then done.
- REQ-042: endAddr=0, enable=1 -> no memReq; done=1 within 2 cycles.
- REQ-043: reset=0 for one cycle mid-run with a request outstanding -> all outputs 0; the late memValid is ignored; after enable, fetch restarts at address 0.
- REQ-044: 3-cycle memory latency, endAddr=5 -> one outstanding request at a time, 5 start pulses, pc 0..4 in order.
